// File: rtl/riscv_aes_block_stager.sv
// Multi-bank staging buffer between the CPU store path and the AES engine.
// The CPU fills one bank with byte-enabled word writes and commits it; committed banks drain in order.
module riscv_aes_block_stager #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 4,
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              test_en_i,
    input  logic                              clear_i,
    input  logic [ADDR_WIDTH-1:0]             waddr_i,
    input  logic [DATA_WIDTH-1:0]             wdata_i,
    input  logic [DATA_WIDTH/8-1:0]           wbe_i,
    input  logic                              wen_i,
    input  logic                              commit_i,
    output logic                              wready_o,
    output logic [NUM_WORDS-1:0]              fill_mask_o,
    output logic                              blk_valid_o,
    input  logic                              blk_ready_i,
    output logic [NUM_WORDS*DATA_WIDTH-1:0]   blk_data_o,
    output logic [$clog2(NUM_BANKS+1)-1:0]    count_o,
    output logic                              err_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(NUM_BANKS);
    localparam int CNT_W = $clog2(NUM_BANKS + 1);

    typedef logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] block_t;

    block_t               mem_q [NUM_BANKS];
    block_t               mem_d [NUM_BANKS];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_WORDS-1:0] fill_mask_q, fill_mask_d;
    logic                 err_q, err_d;

    logic                 wready;
    logic                 valid;
    logic                 wr_ok;
    logic [NUM_WORDS-1:0] wr_onehot;
    logic [NUM_WORDS-1:0] mask_next;
    logic                 commit_ok;
    logic                 err_ev;
    logic                 pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_BANKS - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        wready    = (count_q != CNT_W'(NUM_BANKS));
        valid     = (count_q != '0);
        wr_ok     = wen_i & wready & (|wbe_i);
        wr_onehot = '0;
        if (wr_ok) begin
            wr_onehot[waddr_i] = 1'b1;
        end
        // A write in the commit cycle counts toward completing the mask.
        mask_next = fill_mask_q | wr_onehot;
        commit_ok = commit_i & wready & (&mask_next);
        err_ev    = (wen_i & ~wready) | (commit_i & ~commit_ok);
        pop       = valid & blk_ready_i;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fill_mask_d = fill_mask_q;
        err_d       = err_q;
        if (clear_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            fill_mask_d = '0;
            err_d       = 1'b0;
        end else begin
            fill_mask_d = commit_ok ? '0 : mask_next;
            if (commit_ok) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({commit_ok, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            err_d = err_q | err_ev;
        end
    end

    // Test mode overrides every stored word, even during a flush.
    always_comb begin
        mem_d = mem_q;
        if (test_en_i) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                mem_d[b] = '1;
            end
        end else if (wr_ok && !clear_i) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wbe_i[k]) begin
                    mem_d[wr_ptr_q][waddr_i][8*k +: 8] = wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                mem_q[b] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fill_mask_q <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                mem_q[b] <= mem_d[b];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fill_mask_q <= fill_mask_d;
            err_q       <= err_d;
        end
    end

    assign wready_o    = wready;
    assign blk_valid_o = valid;
    assign blk_data_o  = mem_q[rd_ptr_q];
    assign fill_mask_o = fill_mask_q;
    assign count_o     = count_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_riscv_aes_block_stager.sv
// Bench for riscv_aes_block_stager: queue-of-blocks reference model, separate pop monitor.
module tb_riscv_aes_block_stager;

    localparam int DW = 32;
    localparam int NW = 4;
    localparam int NB = 2;
    localparam int BW = DW * NW;

    logic          clk;
    logic          rst_n;
    logic          test_en_i;
    logic          clear_i;
    logic [1:0]    waddr_i;
    logic [DW-1:0] wdata_i;
    logic [3:0]    wbe_i;
    logic          wen_i;
    logic          commit_i;
    logic          wready_o;
    logic [NW-1:0] fill_mask_o;
    logic          blk_valid_o;
    logic          blk_ready_i;
    logic [BW-1:0] blk_data_o;
    logic [1:0]    count_o;
    logic          err_o;

    riscv_aes_block_stager dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .test_en_i   (test_en_i),
        .clear_i     (clear_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .wbe_i       (wbe_i),
        .wen_i       (wen_i),
        .commit_i    (commit_i),
        .wready_o    (wready_o),
        .fill_mask_o (fill_mask_o),
        .blk_valid_o (blk_valid_o),
        .blk_ready_i (blk_ready_i),
        .blk_data_o  (blk_data_o),
        .count_o     (count_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: committed blocks waiting for the engine, plus per-bank contents.
    logic [BW-1:0] exp_q [$];
    logic [BW-1:0] bank [NB];
    int            wp;
    logic [3:0]    m_mask;
    logic          m_err;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int b = 0; b < NB; b++) bank[b] = '0;
        wp     = 0;
        m_mask = '0;
        m_err  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wready"}, BW'(wready_o), BW'(1));
        chk({tag, "_valid"},  BW'(blk_valid_o), BW'(0));
        chk({tag, "_data"},   blk_data_o, '0);
        chk({tag, "_mask"},   BW'(fill_mask_o), BW'(0));
        chk({tag, "_count"},  BW'(count_o), BW'(0));
        chk({tag, "_err"},    BW'(err_o), BW'(0));
    endtask

    task automatic check_outputs();
        chk("count",  BW'(count_o), BW'(exp_q.size()));
        chk("wready", BW'(wready_o), BW'(exp_q.size() < NB));
        chk("valid",  BW'(blk_valid_o), BW'(exp_q.size() != 0));
        chk("mask",   BW'(fill_mask_o), BW'(m_mask));
        chk("err",    BW'(err_o), BW'(m_err));
        if (exp_q.size() != 0) chk("present", blk_data_o, exp_q[0]);
    endtask

    // One clock: drive at posedge+1, predict from pre-edge model, apply after the edge.
    task automatic cyc(input logic wen, input logic [1:0] addr, input logic [DW-1:0] wd,
                       input logic [3:0] be, input logic cm, input logic rdy,
                       input logic clr, input logic ten);
        int         cnt;
        logic       room, p_wr, p_cm, p_err;
        logic [3:0] p_mask;
        wen_i = wen; waddr_i = addr; wdata_i = wd; wbe_i = be;
        commit_i = cm; blk_ready_i = rdy; clear_i = clr; test_en_i = ten;
        cnt    = exp_q.size();
        room   = (cnt < NB);
        p_wr   = wen & room & (be != 4'h0);
        p_mask = m_mask | (p_wr ? (4'b0001 << addr) : 4'b0000);
        p_cm   = cm & room & (p_mask == 4'hF);
        p_err  = (wen & ~room) | (cm & ~p_cm);
        @(posedge clk);
        #1;
        if (clr) begin
            exp_q.delete();
            wp     = 0;
            m_mask = '0;
            m_err  = 1'b0;
        end else begin
            if (p_wr && !ten) begin
                for (int k = 0; k < 4; k++)
                    if (be[k]) bank[wp][int'(addr)*DW + 8*k +: 8] = wd[8*k +: 8];
            end
            m_mask = p_mask;
            if (p_cm) begin
                exp_q.push_back(bank[wp]);
                wp     = (wp + 1) % NB;
                m_mask = '0;
            end
            if (p_err) m_err = 1'b1;
        end
        if (ten) begin
            for (int b = 0; b < NB; b++) bank[b] = '1;
            for (int i = 0; i < exp_q.size(); i++) exp_q[i] = '1;
        end
        check_outputs();
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 2'd0, '0, 4'h0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    task automatic write_block(input logic [BW-1:0] blk, input logic cm_last, input logic rdy_last);
        for (int w = 0; w < NW; w++)
            cyc(1'b1, 2'(w), blk[w*DW +: DW], 4'hF, (w == NW-1) & cm_last,
                (w == NW-1) & rdy_last, 1'b0, 1'b0);
    endtask

    // Monitor: a block accepted at the coming edge must match the oldest expected block.
    always @(negedge clk) begin
        if (rst_n && blk_valid_o && blk_ready_i && !clear_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got %0h expected no valid block", blk_data_o);
            end else begin
                chk("popped_block", blk_data_o, exp_q.pop_front());
            end
        end
    end

    localparam logic [BW-1:0] BLK_A = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [BW-1:0] BLK_C = 128'h44444444_33333333_22222222_11111111;

    initial begin
        rst_n = 1'b0; test_en_i = 0; clear_i = 0; waddr_i = '0; wdata_i = '0;
        wbe_i = '0; wen_i = 0; commit_i = 0; blk_ready_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Basic fill and commit
        write_block(BLK_A, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, '0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("blkA_data", blk_data_o, BLK_A);
        chk("blkA_count", BW'(count_o), BW'(1));
        idle(1'b1);

        // Byte enables on word 1
        cyc(1'b1, 2'd0, 32'h01010101, 4'hF, 0, 0, 0, 0);
        cyc(1'b1, 2'd1, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0);
        cyc(1'b1, 2'd1, 32'h11223344, 4'h5, 0, 0, 0, 0);
        cyc(1'b1, 2'd2, 32'h02020202, 4'h0, 0, 0, 0, 0);
        chk("be_zero_noerr", BW'(err_o), BW'(0));
        cyc(1'b1, 2'd2, 32'h02020202, 4'hF, 0, 0, 0, 0);
        cyc(1'b1, 2'd3, 32'h03030303, 4'hF, 1, 0, 0, 0);
        chk("be_word1", BW'(blk_data_o[63:32]), BW'(32'hAA22CC44));

        // Fill to full, then illegal write and commit
        write_block(BLK_C, 1'b1, 1'b0);
        chk("full_count", BW'(count_o), BW'(2));
        chk("full_wready", BW'(wready_o), BW'(0));
        cyc(1'b1, 2'd0, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
        chk("full_write_err", BW'(err_o), BW'(1));
        cyc(1'b0, 2'd0, '0, 4'h0, 1, 0, 0, 0);
        idle(1'b1);
        chk("after_pop_data", blk_data_o, BLK_C);
        chk("after_pop_wready", BW'(wready_o), BW'(1));

        // Incomplete commit, then completing write in the commit cycle
        cyc(1'b1, 2'd0, 32'hA0A0A0A0, 4'hF, 0, 0, 0, 0);
        cyc(1'b1, 2'd1, 32'hA1A1A1A1, 4'hF, 0, 0, 0, 0);
        cyc(1'b1, 2'd2, 32'hA2A2A2A2, 4'hF, 0, 0, 0, 0);
        cyc(1'b0, 2'd0, '0, 4'h0, 1, 0, 0, 0);
        chk("incomplete_mask", BW'(fill_mask_o), BW'(4'b0111));
        chk("incomplete_count", BW'(count_o), BW'(1));
        cyc(1'b1, 2'd3, 32'hA3A3A3A3, 4'hF, 1, 0, 0, 0);
        chk("late_commit_count", BW'(count_o), BW'(2));

        // Flush with two committed banks and err set
        cyc(1'b1, 2'd0, 32'h12345678, 4'hF, 1, 1, 1, 0);
        chk("clear_count", BW'(count_o), BW'(0));
        chk("clear_err", BW'(err_o), BW'(0));
        chk("clear_valid", BW'(blk_valid_o), BW'(0));

        // Commit and pop together at count 1
        write_block(BLK_A, 1'b1, 1'b0);
        write_block(BLK_C, 1'b1, 1'b1);
        chk("cp_count", BW'(count_o), BW'(1));
        chk("cp_data", blk_data_o, BLK_C);

        // Test mode forces all-ones storage
        cyc(1'b1, 2'd0, 32'h0, 4'hF, 0, 0, 0, 1);
        chk("test_en_data", blk_data_o, '1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 9) < 7, 2'($urandom), $urandom, 4'($urandom),
                $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
                $urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0);

        // Asynchronous reset mid-fill
        cyc(1'b1, 2'd1, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 100; i++)
            cyc($urandom_range(0, 9) < 8, 2'($urandom), $urandom, 4'($urandom),
                $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 5, 1'b0, 1'b0);
        repeat (NB + 1) idle(1'b1);
        chk("drained_count", BW'(count_o), BW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
